// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier: FSM encoding,
// last step index and the per-step partial-product shift amounts.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] STEP_LAST = 2'd3;

    localparam int unsigned SH0 = 0;
    localparam int unsigned SH1 = 4;
    localparam int unsigned SH2 = 4;
    localparam int unsigned SH3 = 8;

    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = SH0[3:0];
            2'd1:    sh = SH1[3:0];
            2'd2:    sh = SH2[3:0];
            default: sh = SH3[3:0];
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/seq_mult8_ctrl_vedic4x4.sv
// Combinational 4x4 unsigned multiplier built from four vedic 2x2 blocks
// (vertical-and-crosswise partial products, summed with nibble alignment).
module vedic4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);

    function automatic logic [3:0] mul2(input logic [1:0] u, input logic [1:0] v);
        logic [3:0] r;
        logic       c1;
        r[0] = u[0] & v[0];
        r[1] = (u[1] & v[0]) ^ (u[0] & v[1]);
        c1   = (u[1] & v[0]) & (u[0] & v[1]);
        r[2] = (u[1] & v[1]) ^ c1;
        r[3] = (u[1] & v[1]) & c1;
        return r;
    endfunction

    logic [3:0] q0, q1, q2, q3;

    always_comb begin
        q0 = mul2(x[1:0], y[1:0]);
        q1 = mul2(x[3:2], y[1:0]);
        q2 = mul2(x[1:0], y[3:2]);
        q3 = mul2(x[3:2], y[3:2]);
        p  = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    end

endmodule

// File: rtl/seq_mult8_ctrl.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 multiplier, four shift-and-add
// steps, valid/ready on input and result. SEQ_MULT_ZERO_SKIP_EN enables zero-operand bypass.
module seq_mult8_ctrl
    import seq_mult_pkg::*;
#(
    parameter int DW          = 8,
    parameter bit HOLD_OUTPUT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   product,
    output logic          busy
);

    generate
        if (DW != 8) begin : g_dw_check
            $error("seq_mult8_ctrl supports only DW=8");
        end
    endgenerate

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc, product_q;
    logic [3:0]  nib_x, nib_y;
    logic [7:0]  pp;
    logic [15:0] pp_sh, acc_sum;
    logic        accept, out_hs, zero_op;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Step 0/2 use the low multiplicand nibble, 1/3 the high; steps 2/3 use the high multiplier nibble.
    always_comb begin
        nib_x   = step[0] ? a_q[7:4] : a_q[3:0];
        nib_y   = step[1] ? b_q[7:4] : b_q[3:0];
        pp_sh   = {8'b0, pp} << step_shift(step);
        acc_sum = acc + pp_sh;
    end

    vedic4x4 u_vedic (
        .x (nib_x),
        .y (nib_y),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = zero_op ? ST_DONE : ST_MUL;
            ST_MUL:  if (step == STEP_LAST) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept)         state_nxt = zero_op ? ST_DONE : ST_MUL;
                else if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        accept    = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        product   = product_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step      <= 2'd0;
            acc       <= 16'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            product_q <= 16'd0;
        end else begin
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                acc  <= 16'd0;
                step <= 2'd0;
            end else if (state == ST_MUL) begin
                acc <= acc_sum;
                if (step != STEP_LAST) step <= step + 2'd1;
            end

            // The result register only moves on entry to DONE or on a clearing handshake.
            if ((state == ST_MUL) && (step == STEP_LAST))
                product_q <= acc_sum;
            else if (accept && zero_op)
                product_q <= 16'd0;
            else if (out_hs && !HOLD_OUTPUT)
                product_q <= 16'd0;
        end
    end

endmodule
